fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 169 ++++++++++++++++
 tb/tb_fetch_queue.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Two-wide instruction fetch queue between fetch and decode.
//               Circular buffer of {instr, pc, pred} entries with a read
//               pointer, a write pointer and an occupancy counter. Up to two
//               entries enqueue and two dequeue per cycle.
//               Optional macro FETCH_QUEUE_HIGHWATER_EN adds output hwm, the
//               peak occupancy since reset.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
  parameter int DEPTH = 8,   // entry count, power of two, at least 4
  parameter int PC_W  = 11   // instruction address width
) (
  input  logic                     clk,
  input  logic                     rst,          // synchronous, active-low
  input  logic                     enable,
  input  logic                     flush,
  input  logic [1:0]               enq_valid,
  input  logic [31:0]              enq_instr0,
  input  logic [31:0]              enq_instr1,
  input  logic [PC_W-1:0]          enq_pc0,
  input  logic [PC_W-1:0]          enq_pc1,
  input  logic                     enq_pred0,
  input  logic                     enq_pred1,
  output logic                     enq_ready,
  output logic [1:0]               deq_valid,
  output logic [31:0]              deq_instr0,
  output logic [31:0]              deq_instr1,
  output logic [PC_W-1:0]          deq_pc0,
  output logic [PC_W-1:0]          deq_pc1,
  output logic                     deq_pred0,
  output logic                     deq_pred1,
  input  logic [1:0]               deq_take,
  output logic [$clog2(DEPTH):0]   count
`ifdef FETCH_QUEUE_HIGHWATER_EN
  ,
  output logic [$clog2(DEPTH):0]   hwm
`endif
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;

  // Entry storage, deliberately not reset: a zeroed count hides stale data.
  logic [31:0]        r_instrMem [DEPTH];
  logic [PC_W-1:0]    r_pcMem    [DEPTH];
  logic               r_predMem  [DEPTH];

  logic [c_PTR_W-1:0] r_rdPtr;
  logic [c_PTR_W-1:0] r_wrPtr;
  logic [c_CNT_W-1:0] r_count;

  logic               w_advance;
  logic [1:0]         w_nEnq;
  logic [1:0]         w_nDeq;
  logic [1:0]         w_takeMasked;
  logic [c_PTR_W-1:0] w_wrPtr1;
  logic [c_PTR_W-1:0] w_rdPtr1;
  logic [c_CNT_W-1:0] w_countNext;

  // Queue only moves when enabled and not being flushed.
  assign w_advance = enable & ~flush;

  // Room for a full pair is judged on registered occupancy alone, so this
  // never depends on what decode takes in the same cycle.
  assign enq_ready = (r_count <= c_CNT_W'(DEPTH - 2));

  assign deq_valid[0] = (r_count >= c_CNT_W'(1));
  assign deq_valid[1] = (r_count >= c_CNT_W'(2));

  // Take requests for entries that are not present are dropped.
  assign w_takeMasked = deq_take & deq_valid;

  assign w_wrPtr1 = r_wrPtr + c_PTR_W'(1);
  assign w_rdPtr1 = r_rdPtr + c_PTR_W'(1);

  // Enqueue count: slot1 alone (10) is not a legal pattern and is ignored.
  always_comb begin
    w_nEnq = 2'd0;
    if (w_advance && enq_ready) begin
      case (enq_valid)
        2'b01:   w_nEnq = 2'd1;
        2'b11:   w_nEnq = 2'd2;
        default: w_nEnq = 2'd0;
      endcase
    end
  end

  // Dequeue count: head+1 may only be taken together with the head.
  always_comb begin
    w_nDeq = 2'd0;
    if (w_advance) begin
      case (w_takeMasked)
        2'b01:   w_nDeq = 2'd1;
        2'b11:   w_nDeq = 2'd2;
        default: w_nDeq = 2'd0;
      endcase
    end
  end

  // Net occupancy after this edge, enqueue and dequeue applied together.
  assign w_countNext = r_count + c_CNT_W'(w_nEnq) - c_CNT_W'(w_nDeq);

  // Pointer and occupancy state; reset beats flush, flush beats traffic.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else if (enable) begin
      if (flush) begin
        r_rdPtr <= '0;
        r_wrPtr <= '0;
        r_count <= '0;
      end else begin
        r_rdPtr <= r_rdPtr + c_PTR_W'(w_nDeq);
        r_wrPtr <= r_wrPtr + c_PTR_W'(w_nEnq);
        r_count <= w_countNext;
      end
    end
  end

  // Storage writes: slot0 at the write pointer, slot1 right after it.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (w_nEnq != 2'd0) begin
        r_instrMem[r_wrPtr] <= enq_instr0;
        r_pcMem[r_wrPtr]    <= enq_pc0;
        r_predMem[r_wrPtr]  <= enq_pred0;
      end
      if (w_nEnq == 2'd2) begin
        r_instrMem[w_wrPtr1] <= enq_instr1;
        r_pcMem[w_wrPtr1]    <= enq_pc1;
        r_predMem[w_wrPtr1]  <= enq_pred1;
      end
    end
  end

  // Head and head+1 are presented combinationally from storage.
  always_comb begin
    deq_instr0 = r_instrMem[r_rdPtr];
    deq_pc0    = r_pcMem[r_rdPtr];
    deq_pred0  = r_predMem[r_rdPtr];
    deq_instr1 = r_instrMem[w_rdPtr1];
    deq_pc1    = r_pcMem[w_rdPtr1];
    deq_pred1  = r_predMem[w_rdPtr1];
  end

  assign count = r_count;

`ifdef FETCH_QUEUE_HIGHWATER_EN
  logic [c_CNT_W-1:0] r_hwm;

  // Peak occupancy since reset; a flush empties the queue but keeps the peak.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_hwm <= '0;
    end else if (enable && !flush && (w_countNext > r_hwm)) begin
      r_hwm <= w_countNext;
    end
  end

  assign hwm = r_hwm;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_queue
// Description : Self-checking bench for fetch_queue: vector table plus
//               scoreboard of enqueued entries compared at the head outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

  localparam int DEPTH = 8;
  localparam int PC_W  = 11;

  logic            clk = 1'b0;
  logic            rst;
  logic            enable;
  logic            flush;
  logic [1:0]      enq_valid;
  logic [31:0]     enq_instr0, enq_instr1;
  logic [PC_W-1:0] enq_pc0, enq_pc1;
  logic            enq_pred0, enq_pred1;
  logic            enq_ready;
  logic [1:0]      deq_valid;
  logic [31:0]     deq_instr0, deq_instr1;
  logic [PC_W-1:0] deq_pc0, deq_pc1;
  logic            deq_pred0, deq_pred1;
  logic [1:0]      deq_take;
  logic [3:0]      count;
`ifdef FETCH_QUEUE_HIGHWATER_EN
  logic [3:0]      hwm;
`endif

  fetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk(clk), .rst(rst), .enable(enable), .flush(flush),
    .enq_valid(enq_valid),
    .enq_instr0(enq_instr0), .enq_instr1(enq_instr1),
    .enq_pc0(enq_pc0), .enq_pc1(enq_pc1),
    .enq_pred0(enq_pred0), .enq_pred1(enq_pred1),
    .enq_ready(enq_ready), .deq_valid(deq_valid),
    .deq_instr0(deq_instr0), .deq_instr1(deq_instr1),
    .deq_pc0(deq_pc0), .deq_pc1(deq_pc1),
    .deq_pred0(deq_pred0), .deq_pred1(deq_pred1),
    .deq_take(deq_take), .count(count)
`ifdef FETCH_QUEUE_HIGHWATER_EN
    , .hwm(hwm)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]     instr;
    logic [PC_W-1:0] pc;
    logic            pred;
  } ent_t;

  typedef struct {
    logic       en;
    logic       fl;
    logic [1:0] ev;
    logic [1:0] tk;
    int         expCount;
    logic [1:0] expDv;
    logic       expRdy;
  } vec_t;

  ent_t            sb[$];
  vec_t            vecs[15];
  logic [PC_W-1:0] nextPc;
  int              nChecks = 0;
  int              nErrors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive, compare pre-edge outputs against the scoreboard,
  // update the scoreboard for this edge, then cross the edge.
  task automatic step(input logic en, input logic fl, input logic [1:0] ev, input logic [1:0] tk);
    int   sz;
    int   n;
    bit   accept;
    ent_t e0, e1;
    enable     = en;
    flush      = fl;
    enq_valid  = ev;
    deq_take   = tk;
    enq_pc0    = nextPc;
    enq_pc1    = nextPc + 11'd1;
    enq_instr0 = $urandom;
    enq_instr1 = $urandom;
    enq_pred0  = 1'($urandom);
    enq_pred1  = 1'($urandom);
    #1;
    sz = sb.size();
    chk("count", 64'(count), 64'(sz));
    chk("enq_ready", 64'(enq_ready), 64'(sz <= DEPTH - 2));
    chk("deq_valid", 64'(deq_valid), 64'({sz >= 2, sz >= 1}));
    if (sz >= 1) chk("head0", 64'({deq_instr0, deq_pc0, deq_pred0}), 64'({sb[0].instr, sb[0].pc, sb[0].pred}));
    if (sz >= 2) chk("head1", 64'({deq_instr1, deq_pc1, deq_pred1}), 64'({sb[1].instr, sb[1].pc, sb[1].pred}));
    if (en) begin
      if (fl) begin
        sb.delete();
      end else begin
        n = 0;
        if (tk == 2'b01 && sz >= 1) n = 1;
        else if (tk == 2'b11) n = (sz >= 2) ? 2 : ((sz >= 1) ? 1 : 0);
        accept = (sz <= DEPTH - 2);
        for (int i = 0; i < n; i++) void'(sb.pop_front());
        if (accept && ev[0]) begin
          e0.instr = enq_instr0; e0.pc = enq_pc0; e0.pred = enq_pred0;
          sb.push_back(e0);
          nextPc = nextPc + 11'd1;
          if (ev[1]) begin
            e1.instr = enq_instr1; e1.pc = enq_pc1; e1.pred = enq_pred1;
            sb.push_back(e1);
            nextPc = nextPc + 11'd1;
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Reset with caller-chosen enable/flush to show reset takes priority.
  task automatic doReset(input logic en, input logic fl);
    rst       = 1'b0;
    enable    = en;
    flush     = fl;
    enq_valid = 2'b11;
    deq_take  = 2'b11;
    @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    nextPc = '0;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_deq_valid", 64'(deq_valid), 64'd0);
    chk("rst_enq_ready", 64'(enq_ready), 64'd1);
  endtask

  initial begin
    rst = 1'b0; enable = 1'b0; flush = 1'b0; enq_valid = 2'b00; deq_take = 2'b00;
    enq_instr0 = '0; enq_instr1 = '0; enq_pc0 = '0; enq_pc1 = '0;
    enq_pred0 = 1'b0; enq_pred1 = 1'b0; nextPc = '0;

    //          en    fl    ev     tk    cnt dv     rdy
    vecs[0]  = '{1'b1, 1'b0, 2'b11, 2'b00, 2, 2'b11, 1'b1};
    vecs[1]  = '{1'b1, 1'b0, 2'b11, 2'b00, 4, 2'b11, 1'b1};
    vecs[2]  = '{1'b1, 1'b0, 2'b11, 2'b00, 6, 2'b11, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 2'b11, 2'b00, 8, 2'b11, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 2'b11, 2'b00, 8, 2'b11, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 2'b00, 2'b01, 7, 2'b11, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 2'b11, 2'b11, 5, 2'b11, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 2'b11, 2'b11, 5, 2'b11, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 2'b11, 2'b11, 0, 2'b00, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 2'b01, 2'b00, 1, 2'b01, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 2'b10, 2'b00, 1, 2'b01, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 2'b00, 2'b10, 1, 2'b01, 1'b1};
    vecs[12] = '{1'b1, 1'b0, 2'b11, 2'b11, 2, 2'b11, 1'b1};
    vecs[13] = '{1'b1, 1'b0, 2'b00, 2'b11, 0, 2'b00, 1'b1};
    vecs[14] = '{1'b1, 1'b0, 2'b00, 2'b01, 0, 2'b00, 1'b1};

    @(posedge clk);
    doReset(1'b1, 1'b0);

    for (int v = 0; v < 15; v++) begin
      step(vecs[v].en, vecs[v].fl, vecs[v].ev, vecs[v].tk);
      chk($sformatf("vec%0d_count", v), 64'(count), 64'(vecs[v].expCount));
      chk($sformatf("vec%0d_deq_valid", v), 64'(deq_valid), 64'(vecs[v].expDv));
      chk($sformatf("vec%0d_enq_ready", v), 64'(enq_ready), 64'(vecs[v].expRdy));
      if (v == 0) begin
        chk("first_pc0", 64'(deq_pc0), 64'd0);
        chk("first_pc1", 64'(deq_pc1), 64'd1);
      end
    end

    // Wrap: fill to 6, drain 4, add 4 so the write pointer passes index 7.
    doReset(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2'b11, 2'b00);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 2'b00, 2'b11);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 2'b11, 2'b00);
    chk("wrap_count", 64'(count), 64'd6);
    chk("wrap_head_pc", 64'(deq_pc0), 64'd4);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("wrap_order%0d", i), 64'({deq_pc1, deq_pc0}),
          64'({11'(5 + 2 * i), 11'(4 + 2 * i)}));
      step(1'b1, 1'b0, 2'b00, 2'b11);
    end
    chk("wrap_empty", 64'(count), 64'd0);

    // Mid-operation reset with enable low and flush high still empties.
    step(1'b1, 1'b0, 2'b11, 2'b00);
    step(1'b1, 1'b0, 2'b01, 2'b00);
    doReset(1'b0, 1'b1);

    // Mixed traffic cross-checked by the scoreboard.
    for (int i = 0; i < 80; i++) begin
      step(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 14) == 0),
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 2'b00, 2'b11);
    chk("drain_count", 64'(count), 64'd0);

`ifdef FETCH_QUEUE_HIGHWATER_EN
    doReset(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2'b11, 2'b00);
    step(1'b1, 1'b1, 2'b00, 2'b00);
    step(1'b1, 1'b0, 2'b11, 2'b00);
    step(1'b1, 1'b0, 2'b01, 2'b00);
    chk("hwm_count3", 64'(count), 64'd3);
    chk("hwm_peak", 64'(hwm), 64'd6);
    doReset(1'b1, 1'b0);
    chk("hwm_reset", 64'(hwm), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
